// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg: shared types and constants for the debug UART transmitter.
//   state_t     - FSM states used by the framer (IDLE/GATE/START) and the
//                 bit serializer (IDLE/START/DATA/STOP)
//   SYNC_BYTE   - first byte of every frame
//   FRAME_BYTES - bytes per frame (sync + 2 x 16-bit values)
//   frame_byte  - selects the byte to send for a given frame position
package debug_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GATE  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 5;

    // Snapshot layout is {ac, md}; high byte of each value goes first.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [31:0] snap);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = snap[31:24];
            3'd2:    b = snap[23:16];
            3'd3:    b = snap[15:8];
            3'd4:    b = snap[7:0];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/debug_uart_if.sv
// debug_uart_if: snapshot request handshake between the CPU side and the
// debug transmitter.
//   snap_valid - source requests a frame with the current ac_in/md_in
//   snap_ready - transmitter can accept a snapshot
//   ac_in      - 16-bit accumulator value
//   md_in      - 16-bit memory-data value
interface debug_uart_if;
    logic        snap_valid;
    logic        snap_ready;
    logic [15:0] ac_in;
    logic [15:0] md_in;

    modport master (output snap_valid, output ac_in, output md_in, input snap_ready);
    modport slave  (input snap_valid, input ac_in, input md_in, output snap_ready);
endinterface

// File: rtl/debug_uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for one byte.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - start sending data (honoured only while idle)
//   data       - byte to send, LSB first
//   line       - registered serial output, idles high
//   done       - high during the final cycle of the stop bit
module uart_tx_byte
    import debug_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       line,
    output logic       done
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);

    state_t        state_r, state_next;
    logic [CW-1:0] cnt_r, cnt_next;
    logic [3:0]    bit_r, bit_next;      // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]    shift_r, shift_next;
    logic          line_r, line_next;

    // Next-state logic: line_next is the level for the bit that begins next cycle.
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r;
        bit_next   = bit_r;
        shift_next = shift_r;
        line_next  = line_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_next = START;
                    cnt_next   = '0;
                    bit_next   = 4'd0;
                    shift_next = data;
                    line_next  = 1'b0;
                end else begin
                    line_next  = 1'b1;
                end
            end
            START, DATA, STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_next = '0;
                    if (bit_r == 4'd9) begin
                        state_next = IDLE;
                        line_next  = 1'b1;
                    end else if (bit_r == 4'd8) begin
                        bit_next   = bit_r + 4'd1;
                        state_next = STOP;
                        line_next  = 1'b1;
                    end else begin
                        bit_next   = bit_r + 4'd1;
                        state_next = DATA;
                        line_next  = shift_r[0];
                        shift_next = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    cnt_next = cnt_r + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                line_next  = 1'b1;
            end
        endcase
    end

    // Serializer state register; line resets high so reset silences the wire at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            bit_r   <= 4'd0;
            shift_r <= 8'h00;
            line_r  <= 1'b1;
        end else begin
            state_r <= state_next;
            cnt_r   <= cnt_next;
            bit_r   <= bit_next;
            shift_r <= shift_next;
            line_r  <= line_next;
        end
    end

    assign line = line_r;
    assign done = (state_r == STOP) && (cnt_r == CNT_LAST);

endmodule

// File: rtl/debug_uart_tx.sv
// debug_uart_tx: snapshots ac/md and streams A5,ac_hi,ac_lo,md_hi,md_lo as
// 8N1 bytes to the AVR, checking avr_rx_busy before each byte.
//   clk, rst_n  - system clock, asynchronous active-low reset
//   snap        - snapshot handshake (slave side)
//   avr_rx      - serial line to the AVR, idles high
//   avr_rx_busy - AVR buffer full, asynchronous to clk
//   tx_active   - high from acceptance until the last stop bit ends
module debug_uart_tx
    import debug_uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 500_000
) (
    input  logic         clk,
    input  logic         rst_n,
    debug_uart_if.slave  snap,
    output logic         avr_rx,
    input  logic         avr_rx_busy,
    output logic         tx_active
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    state_t      state_r, state_next;
    logic [2:0]  byte_idx_r, byte_idx_next;
    logic [31:0] snap_r, snap_next;
    logic        ready_r, active_r;
    logic        busy_meta_r, busy_s;
    logic        load_s, done_s, line_s;

    // Busy synchronizer; resets to "busy" so nothing goes out before the AVR is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_meta_r <= 1'b1;
            busy_s      <= 1'b1;
        end else begin
            busy_meta_r <= avr_rx_busy;
            busy_s      <= busy_meta_r;
        end
    end

    // Framer next-state logic: IDLE -> GATE -> START (byte in flight) per byte.
    always_comb begin
        state_next    = state_r;
        byte_idx_next = byte_idx_r;
        snap_next     = snap_r;
        load_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (snap.snap_valid && ready_r) begin
                    snap_next     = {snap.ac_in, snap.md_in};
                    byte_idx_next = 3'd0;
                    state_next    = GATE;
                end else begin
                    state_next    = IDLE;
                end
            end
            GATE: begin
                if (!busy_s) begin
                    load_s     = 1'b1;
                    state_next = START;
                end else begin
                    state_next = GATE;
                end
            end
            START: begin
                if (done_s) begin
                    if (byte_idx_r == 3'(FRAME_BYTES - 1)) begin
                        state_next = IDLE;
                    end else begin
                        byte_idx_next = byte_idx_r + 3'd1;
                        state_next    = GATE;
                    end
                end else begin
                    state_next = START;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Framer registers; ready/active are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            byte_idx_r <= 3'd0;
            snap_r     <= 32'h0000_0000;
            ready_r    <= 1'b1;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_next;
            byte_idx_r <= byte_idx_next;
            snap_r     <= snap_next;
            ready_r    <= (state_next == IDLE);
            active_r   <= (state_next != IDLE);
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .data  (frame_byte(byte_idx_r, snap_r)),
        .line  (line_s),
        .done  (done_s)
    );

    assign avr_rx          = line_s;
    assign tx_active       = active_r;
    assign snap.snap_ready = ready_r;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx: one instance at 100 clocks/bit, one at 10.
module tb_debug_uart_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy_a = 1'b0;
    logic busy_b = 1'b0;
    logic rx_a, rx_b, act_a, act_b;

    debug_uart_if if_a ();
    debug_uart_if if_b ();

    debug_uart_tx #(.CLK_HZ(50_000_000), .BAUD(500_000)) dut_a (
        .clk(clk), .rst_n(rst_n), .snap(if_a.slave),
        .avr_rx(rx_a), .avr_rx_busy(busy_a), .tx_active(act_a));

    debug_uart_tx #(.CLK_HZ(50_000_000), .BAUD(5_000_000)) dut_b (
        .clk(clk), .rst_n(rst_n), .snap(if_b.slave),
        .avr_rx(rx_b), .avr_rx_busy(busy_b), .tx_active(act_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic line_of(input int sel);
        return (sel == 0) ? rx_a : rx_b;
    endfunction

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? if_a.snap_ready : if_b.snap_ready;
    endfunction

    // Present a snapshot at a negedge; k is the accepting posedge number.
    task automatic accept(input int sel, input logic [15:0] ac, input logic [15:0] md,
                          input bit hold, output int k);
        int n = 0;
        if (sel == 0) begin
            if_a.ac_in = ac; if_a.md_in = md; if_a.snap_valid = 1'b1;
        end else begin
            if_b.ac_in = ac; if_b.md_in = md; if_b.snap_valid = 1'b1;
        end
        while (ready_of(sel) !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_wait", 32'(n < 20000), 32'd1);
        k = cyc + 1;
        @(negedge clk);
        if (!hold) begin
            if (sel == 0) if_a.snap_valid = 1'b0;
            else          if_b.snap_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for a low line; start is the posedge that drove it low.
    task automatic wait_start(input int sel, input int limit, output int start);
        int n = 0;
        while (line_of(sel) !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_val("start_wait", 32'(n < limit), 32'd1);
        start = cyc;
    endtask

    // Decode one byte; good clears if any bit is not constant for exactly cpb cycles
    // or if start/stop levels are wrong.
    task automatic rx_byte(input int sel, input int cpb, output logic [7:0] data,
                           output int start, output logic good);
        logic [9:0] bits;
        logic v;
        good = 1'b1;
        bits = 10'h000;
        wait_start(sel, 20000, start);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < cpb; c++) begin
                if (j != 0 || c != 0) @(negedge clk);
                v = line_of(sel);
                if (c == 0) bits[j] = v;
                else if (v !== bits[j]) good = 1'b0;
            end
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) good = 1'b0;
        data = bits[8:1];
    endtask

    // Receive a full frame with no flow control and check bytes, shape and spacing.
    task automatic rx_frame(input int sel, input int cpb, input logic [15:0] ac,
                            input logic [15:0] md, input int first, input string tag,
                            output int last_start);
        logic [39:0] exp_v;
        logic [7:0]  d;
        logic        g;
        int          s, prev;
        exp_v = {8'hA5, ac, md};
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            rx_byte(sel, cpb, d, s, g);
            check_val({tag, "_byte"}, 32'(d), 32'(exp_v[39-8*i -: 8]));
            check_val({tag, "_shape"}, 32'(g), 32'd1);
            if (i == 0) check_val({tag, "_first_start"}, s, first);
            else        check_val({tag, "_byte_gap"}, s - prev, 10 * cpb + 1);
            prev = s;
        end
        last_start = s;
    endtask

    initial begin
        int k, ls, s, prev, c0, lows;
        logic [7:0] d;
        logic g;

        if_a.snap_valid = 1'b0; if_a.ac_in = 16'h0000; if_a.md_in = 16'h0000;
        if_b.snap_valid = 1'b0; if_b.ac_in = 16'h0000; if_b.md_in = 16'h0000;

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_avr_rx", 32'(rx_a), 32'd1);
        check_val("rst_ready", 32'(if_a.snap_ready), 32'd1);
        check_val("rst_active", 32'(act_a), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame, exact start latency and 5005-cycle frame time
        accept(0, 16'h1234, 16'hBEEF, 1'b0, k);
        check_val("t1_ready_low", 32'(if_a.snap_ready), 32'd0);
        check_val("t1_active_high", 32'(act_a), 32'd1);
        rx_frame(0, 100, 16'h1234, 16'hBEEF, k + 1, "t1", ls);
        check_val("t1_ready_before_end", 32'(if_a.snap_ready), 32'd0);
        @(negedge clk);
        check_val("t1_frame_cycles", cyc - k, 5005);
        check_val("t1_ready_end", 32'(if_a.snap_ready), 32'd1);
        check_val("t1_active_end", 32'(act_a), 32'd0);

        // Input stability: ac changes right after acceptance
        accept(0, 16'h1234, 16'h5678, 1'b0, k);
        if_a.ac_in = 16'hFFFF;
        rx_frame(0, 100, 16'h1234, 16'h5678, k + 1, "stab", ls);
        repeat (2) @(negedge clk);

        // Flow control: busy before acceptance, then busy raised during byte 2
        busy_a = 1'b1;
        repeat (4) @(negedge clk);
        accept(0, 16'hA55A, 16'h0F0F, 1'b0, k);
        lows = 0;
        repeat (2000) begin
            @(negedge clk);
            if (rx_a !== 1'b1) lows++;
        end
        check_val("fc_held_idle", lows, 0);
        check_val("fc_active_in_gate", 32'(act_a), 32'd1);
        busy_a = 1'b0;
        c0 = cyc;
        rx_byte(0, 100, d, s, g);
        check_val("fc_b0", 32'(d), 32'hA5);
        check_val("fc_release_latency", 32'((s - c0) >= 2 && (s - c0) <= 3), 32'd1);
        prev = s;
        rx_byte(0, 100, d, s, g);
        check_val("fc_b1", 32'(d), 32'hA5);
        check_val("fc_b1_gap", s - prev, 1001);
        prev = s;
        fork
            rx_byte(0, 100, d, s, g);
            begin
                repeat (300) @(negedge clk);
                busy_a = 1'b1;
            end
        join
        check_val("fc_b2", 32'(d), 32'h5A);
        check_val("fc_b2_shape", 32'(g), 32'd1);
        check_val("fc_b2_gap", s - prev, 1001);
        lows = 0;
        repeat (500) begin
            @(negedge clk);
            if (rx_a !== 1'b1) lows++;
        end
        check_val("fc_b3_held", lows, 0);
        busy_a = 1'b0;
        c0 = cyc;
        rx_byte(0, 100, d, s, g);
        check_val("fc_b3", 32'(d), 32'h0F);
        check_val("fc_b3_latency", 32'((s - c0) >= 2 && (s - c0) <= 3), 32'd1);
        prev = s;
        rx_byte(0, 100, d, s, g);
        check_val("fc_b4", 32'(d), 32'h0F);
        check_val("fc_b4_gap", s - prev, 1001);
        repeat (2) @(negedge clk);

        // Back-to-back frames with snap_valid held high
        accept(0, 16'h1357, 16'h9BDF, 1'b1, k);
        if_a.ac_in = 16'h2468;
        if_a.md_in = 16'hACE0;
        rx_frame(0, 100, 16'h1357, 16'h9BDF, k + 1, "b2b1", ls);
        fork
            rx_frame(0, 100, 16'h2468, 16'hACE0, k + 5007, "b2b2", ls);
            begin
                @(negedge clk);
                check_val("b2b_ready_gap", 32'(if_a.snap_ready), 32'd1);
                @(negedge clk);
                check_val("b2b_reaccepted", 32'(if_a.snap_ready), 32'd0);
                repeat (5) @(negedge clk);
                if_a.snap_valid = 1'b0;
            end
        join
        @(negedge clk);
        check_val("b2b_ready_end", 32'(if_a.snap_ready), 32'd1);
        repeat (2) @(negedge clk);

        // Reset during byte 1 data (slot 3 carries a 0 for 0x12)
        accept(0, 16'h1234, 16'hBEEF, 1'b0, k);
        rx_byte(0, 100, d, s, g);
        wait_start(0, 2000, s);
        repeat (350) @(negedge clk);
        check_val("mr_line_low_before", 32'(rx_a), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_val("mr_line_forced_high", 32'(rx_a), 32'd1);
        check_val("mr_ready", 32'(if_a.snap_ready), 32'd1);
        check_val("mr_active", 32'(act_a), 32'd0);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (rx_a !== 1'b1) lows++;
        end
        rst_n = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (rx_a !== 1'b1 || act_a !== 1'b0) lows++;
        end
        check_val("mr_quiet", lows, 0);
        accept(0, 16'h0001, 16'h0002, 1'b0, k);
        rx_frame(0, 100, 16'h0001, 16'h0002, k + 1, "mr", ls);

        // Ten clocks per bit: 505-cycle frame
        accept(1, 16'hC35A, 16'h7E81, 1'b0, k);
        rx_frame(1, 10, 16'hC35A, 16'h7E81, k + 1, "p10", ls);
        check_val("p10_ready_before_end", 32'(if_b.snap_ready), 32'd0);
        @(negedge clk);
        check_val("p10_frame_cycles", cyc - k, 505);
        check_val("p10_ready_end", 32'(if_b.snap_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
